gate_response_checker: RTL

Response-checking end of the gate-level test flow. A stimulus source drives operand vectors into a logic-gate DUT and, in parallel, into this block. The block computes the expected gate output, delays it to line up with the DUT's pipeline latency, compares it against the observed output, and keeps pass/fail counts plus a capture of the first failing vector. It is synthesizable and sits beside the DUT, so self-checking runs without waveform inspection.

---
 rtl/gate_response_checker_if.sv | 35 +++
 rtl/gate_response_checker.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/gate_response_checker_if.sv
// Bundle between the stimulus/observation side and the gate response checker.
// master: stimulus source (drives start/op/stimulus/obs_y/end_in, reads results).
// slave : the checker itself (reads stimulus, drives status and result fields).
interface gate_response_checker_if #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic [1:0]       op;
  logic             stim_valid;
  logic [WIDTH-1:0] stim_a;
  logic [WIDTH-1:0] stim_b;
  logic [WIDTH-1:0] obs_y;
  logic             end_in;

  logic             busy;
  logic             done;
  logic             pass;
  logic             error;
  logic [CNT_W-1:0] pass_count;
  logic [CNT_W-1:0] fail_count;
  logic [WIDTH-1:0] ff_a;
  logic [WIDTH-1:0] ff_b;
  logic [WIDTH-1:0] ff_y;

  modport master (
    output start, op, stim_valid, stim_a, stim_b, obs_y, end_in,
    input  busy, done, pass, error, pass_count, fail_count, ff_a, ff_b, ff_y
  );

  modport slave (
    input  start, op, stim_valid, stim_a, stim_b, obs_y, end_in,
    output busy, done, pass, error, pass_count, fail_count, ff_a, ff_b, ff_y
  );
endinterface

// File: rtl/gate_response_checker.sv
// Response checker for a bitwise logic-gate DUT. Computes the expected gate
// output for each accepted stimulus, delays it by the DUT latency, compares it
// with the observed output and keeps saturating pass/fail counts plus a capture
// of the first failing vector.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   bus (slave)  : start/op/stim_valid/stim_a/stim_b/obs_y/end_in in;
//                  busy/done/pass/error/pass_count/fail_count/ff_a/ff_b/ff_y out
module gate_response_checker #(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  gate_response_checker_if.slave bus
);

  localparam int unsigned DEPTH = (LATENCY == 0) ? 1 : LATENCY;
  localparam int unsigned DRN_W = 3;
  localparam logic [DRN_W-1:0] DRAIN_LOAD = DRN_W'((LATENCY == 0) ? 0 : LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] exp;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  state_t           state;
  logic [1:0]       op_q;
  logic [DRN_W-1:0] drain_cnt;

  logic             start_ok_c;
  logic             compare_en_c;
  logic             match_c;
  stage_t           in_c;
  stage_t           cmp_c;
  logic [CNT_W-1:0] pass_nxt_c;
  logic [CNT_W-1:0] fail_nxt_c;

  function automatic logic [WIDTH-1:0] gate_f(input logic [1:0] sel,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    case (sel)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~(x & y);
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  // Stimulus capture and compare decision
  always_comb begin
    start_ok_c   = bus.start && ((state == S_IDLE) || (state == S_DONE));
    // start is only honoured outside RUN, so a start-cycle stim_valid is never accepted
    in_c.valid   = bus.stim_valid && (state == S_RUN);
    in_c.exp     = gate_f(op_q, bus.stim_a, bus.stim_b);
    in_c.a       = bus.stim_a;
    in_c.b       = bus.stim_b;
    compare_en_c = cmp_c.valid && ((state == S_RUN) || (state == S_DRAIN));
    match_c      = (bus.obs_y == cmp_c.exp);
    pass_nxt_c   = bus.pass_count;
    fail_nxt_c   = bus.fail_count;
    if (compare_en_c) begin
      if (match_c) pass_nxt_c = sat_inc(bus.pass_count);
      else         fail_nxt_c = sat_inc(bus.fail_count);
    end
  end

  // Expected-value delay line matching the DUT latency (bubbles travel as valid=0)
  generate
    if (LATENCY == 0) begin : g_no_pipe
      assign cmp_c = in_c;
    end else begin : g_pipe
      stage_t pipe [DEPTH];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else if (start_ok_c) begin
          for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= in_c;
          for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign cmp_c = pipe[DEPTH-1];
    end
  endgenerate

  // Run control FSM, result registers and status decodes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      op_q           <= 2'b00;
      drain_cnt      <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.pass       <= 1'b0;
      bus.error      <= 1'b0;
      bus.pass_count <= '0;
      bus.fail_count <= '0;
      bus.ff_a       <= '0;
      bus.ff_b       <= '0;
      bus.ff_y       <= '0;
    end else begin
      if (compare_en_c) begin
        bus.pass_count <= pass_nxt_c;
        bus.fail_count <= fail_nxt_c;
        if (!match_c && !bus.error) begin
          bus.error <= 1'b1;
          bus.ff_a  <= cmp_c.a;
          bus.ff_b  <= cmp_c.b;
          bus.ff_y  <= bus.obs_y;
        end
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (start_ok_c) begin
            state          <= S_RUN;
            op_q           <= bus.op;
            bus.busy       <= 1'b1;
            bus.done       <= 1'b0;
            bus.pass       <= 1'b0;
            bus.error      <= 1'b0;
            bus.pass_count <= '0;
            bus.fail_count <= '0;
            bus.ff_a       <= '0;
            bus.ff_b       <= '0;
            bus.ff_y       <= '0;
          end
        end
        S_RUN: begin
          if (bus.end_in) begin
            if (LATENCY == 0) begin
              state    <= S_DONE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              bus.pass <= (fail_nxt_c == '0);
            end else begin
              state     <= S_DRAIN;
              drain_cnt <= DRAIN_LOAD;
            end
          end
        end
        S_DRAIN: begin
          // last in-flight vector is compared on the cycle the count hits zero
          if (drain_cnt == '0) begin
            state    <= S_DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.pass <= (fail_nxt_c == '0);
          end else begin
            drain_cnt <= drain_cnt - DRN_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
